// File: rtl/aeolus_display_pkg.sv
// Shared definitions for the Aeolus CPU output display stage.
// Holds the converter FSM state encoding, display widths, active-low
// seven-segment codes ({g,f,e,d,c,b,a}) and the double-dabble step helper.
package aeolus_display_pkg;

  localparam int DATA_W  = 8;
  localparam int BCD_W   = 12;
  localparam int SHIFT_W = BCD_W + DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift
  // the whole {bcd, binary} register left by one.
  function automatic logic [SHIFT_W-1:0] bcd_step(input logic [SHIFT_W-1:0] s);
    logic [SHIFT_W-1:0] a;
    a = s;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (a[DATA_W + 4*i +: 4] >= 4'd5)
        a[DATA_W + 4*i +: 4] = a[DATA_W + 4*i +: 4] + 4'd3;
    end
    return {a[SHIFT_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/cpu_out_display_seg7_decode.sv
// seg7_decode: combinational BCD nibble to active-low seven-segment code.
// Ports:
//   nibble  in  4  BCD digit 0..9
//   seg     out 7  {g,f,e,d,c,b,a}, active-low; non-decimal codes go blank
module seg7_decode
  import aeolus_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/cpu_out_display.sv
// cpu_out_display: shows the Aeolus CPU 8-bit result as an unsigned decimal
// value on a 4-digit common-anode multiplexed seven-segment display.
// A sequential double-dabble converter refreshes the BCD display registers
// whenever the sampled input changes; a refresh-driven scanner multiplexes
// the digits with leading-zero blanking.
// Ports:
//   boardCLK  in  1  board clock, rising edge
//   reset     in  1  asynchronous active-low reset
//   cpuOut    in  8  CPU result, unsigned binary
//   segments  out 7  {g,f,e,d,c,b,a}, active-low
//   anodes    out 4  digit enables, active-low, bit 0 = ones digit
//   busy      out 1  high while a conversion is in progress
//
// Converter states:
//   state | meaning
//   IDLE  | waiting for in_q to differ from last converted value
//   SHIFT | 8 double-dabble iterations
//   DONE  | latch hundreds/tens/ones into display registers
module cpu_out_display
  import aeolus_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       boardCLK,
  input  logic       reset,
  input  logic [7:0] cpuOut,
  output logic [6:0] segments,
  output logic [3:0] anodes,
  output logic       busy
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [DATA_W-1:0]  in_q;
  logic [DATA_W-1:0]  last_val;
  conv_state_e        state;
  logic [SHIFT_W-1:0] shift_reg;
  logic [2:0]         cnt;
  logic [3:0]         hund_q;
  logic [3:0]         tens_q;
  logic [3:0]         ones_q;

  logic [CNT_W-1:0]   ref_cnt;
  logic [1:0]         digit_idx;
  logic [3:0]         digit_nib;
  logic               digit_blank;
  logic [6:0]         seg_code;

  always_ff @(posedge boardCLK or negedge reset) begin
    if (!reset) begin
      in_q <= '0;
    end else begin
      in_q <= cpuOut;
    end
  end

  // Converter FSM. A change of in_q during SHIFT/DONE is not lost: last_val
  // still holds the old value, so IDLE restarts on the following cycle.
  always_ff @(posedge boardCLK or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last_val  <= '0;
      shift_reg <= '0;
      cnt       <= '0;
      hund_q    <= '0;
      tens_q    <= '0;
      ones_q    <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_q != last_val) begin
            shift_reg <= {{BCD_W{1'b0}}, in_q};
            last_val  <= in_q;
            cnt       <= '0;
            state     <= SHIFT;
            busy      <= 1'b1;
          end
        end
        SHIFT: begin
          shift_reg <= bcd_step(shift_reg);
          cnt       <= cnt + 3'd1;
          if (cnt == 3'd7)
            state <= DONE;
        end
        DONE: begin
          hund_q <= shift_reg[SHIFT_W-1 -: 4];
          tens_q <= shift_reg[SHIFT_W-5 -: 4];
          ones_q <= shift_reg[SHIFT_W-9 -: 4];
          state  <= IDLE;
          busy   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge boardCLK or negedge reset) begin
    if (!reset) begin
      ref_cnt   <= '0;
      digit_idx <= '0;
    end else begin
      if (ref_cnt == REF_LAST) begin
        ref_cnt   <= '0;
        digit_idx <= digit_idx + 2'd1;
      end else begin
        ref_cnt <= ref_cnt + CNT_W'(1);
      end
    end
  end

  // Digit mux with leading-zero blanking; digit 3 is never used for 0..255.
  always_comb begin
    digit_nib   = ones_q;
    digit_blank = 1'b0;
    case (digit_idx)
      2'd0: begin
        digit_nib   = ones_q;
        digit_blank = 1'b0;
      end
      2'd1: begin
        digit_nib   = tens_q;
        digit_blank = (hund_q == 4'd0) && (tens_q == 4'd0);
      end
      2'd2: begin
        digit_nib   = hund_q;
        digit_blank = (hund_q == 4'd0);
      end
      default: begin
        digit_nib   = 4'd0;
        digit_blank = 1'b1;
      end
    endcase
  end

  seg7_decode u_seg7_decode (
    .nibble (digit_nib),
    .seg    (seg_code)
  );

  // anodes and segments share one register stage so they always move together.
  always_ff @(posedge boardCLK or negedge reset) begin
    if (!reset) begin
      anodes   <= 4'hF;
      segments <= SEG_BLANK;
    end else begin
      if (digit_blank) begin
        anodes   <= 4'hF;
        segments <= SEG_BLANK;
      end else begin
        anodes   <= ~(4'b0001 << digit_idx);
        segments <= seg_code;
      end
    end
  end

endmodule
